// File: rtl/hs_pkg.sv
// Shared definitions for the bit-serial half-subtractor datapath.
package hs_pkg;

  localparam int HS_MAX_WIDTH = 32;

  // Two-bit encoding; code 2'b11 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/hs_cell.sv
// Combinational half subtractor: d = a - b (one bit), bo = borrow out.
module hs_cell (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bo
);

  assign d  = a ^ b;
  assign bo = ~a & b;

endmodule

// File: rtl/hs_serial_sub.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Two chained half-subtractor cells plus a registered borrow form the bit slice.
module hs_serial_sub
  import hs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = ($clog2(WIDTH + 1) < 1) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] diff_sr;
  logic [WIDTH-1:0] diff_next;
  logic [CW-1:0]    cnt;
  logic             brw;

  logic d1, b1, d, b2, bout;

  hs_cell u_hs1 (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .d  (d1),
    .bo (b1)
  );

  hs_cell u_hs2 (
    .a  (d1),
    .b  (brw),
    .d  (d),
    .bo (b2)
  );

  assign bout = b1 | b2;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    diff_next            = diff_sr >> 1;
    diff_next[WIDTH-1]   = d;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      a_sr       <= '0;
      b_sr       <= '0;
      diff_sr    <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= 1'b0;
            cnt   <= '0;
            state <= SHIFT;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SHIFT: begin
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          diff_sr <= diff_next;
          brw     <= bout;
          cnt     <= cnt + 1'b1;
          // Last bit: publish the assembled result together with the final borrow.
          if (cnt == LAST) begin
            diff       <= diff_next;
            borrow_out <= bout;
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hs_serial_sub.sv
// Directed bench for hs_serial_sub: WIDTH=8 vector table plus corner sequences, and a WIDTH=1 instance.
module tb_hs_serial_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] diff;
  logic       borrow_out;

  logic start1, a1, b1;
  logic busy1, done1, diff1, borrow1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hs_serial_sub #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  hs_serial_sub #(.WIDTH(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a          (a1),
    .b          (b1),
    .busy       (busy1),
    .done       (done1),
    .diff       (diff1),
    .borrow_out (borrow1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       bo;
  } vec8_t;

  typedef struct {
    logic a;
    logic b;
    logic diff;
    logic bo;
  } vec1_t;

  vec8_t vecs[7];
  vec1_t vecs1[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands with start for one edge; returns just after the accepting edge.
  task automatic start8(input logic [7:0] va, input logic [7:0] vb);
    a     = va;
    b     = vb;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done (bounded); cyc counts edges after the caller's reference edge.
  task automatic wait_done8(input int already, output int cyc, output int busy_cnt);
    cyc      = -1;
    busy_cnt = busy ? 1 : 0;
    for (int i = already + 1; i <= already + 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        cyc = i;
        break;
      end
      if (busy) busy_cnt++;
    end
  endtask

  initial begin
    int cyc, bcnt;
    int seen;

    vecs[0] = '{8'h5A, 8'h23, 8'h37, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
    vecs[3] = '{8'h10, 8'h01, 8'h0F, 1'b0};
    vecs[4] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    vecs[6] = '{8'h00, 8'hFF, 8'h01, 1'b1};

    vecs1[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    vecs1[1] = '{1'b0, 1'b1, 1'b1, 1'b1};
    vecs1[2] = '{1'b1, 1'b0, 1'b1, 1'b0};
    vecs1[3] = '{1'b1, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset diff", diff, 0);
    check("reset borrow", borrow_out, 0);
    check("reset w1 busy/done", {busy1, done1, diff1, borrow1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven operations with latency and busy-window checks.
    foreach (vecs[i]) begin
      start8(vecs[i].a, vecs[i].b);
      check($sformatf("v%0d busy after accept", i), busy, 1);
      wait_done8(0, cyc, bcnt);
      check($sformatf("v%0d done latency", i), cyc, 8);
      check($sformatf("v%0d busy cycles", i), bcnt, 8);
      check($sformatf("v%0d busy at done", i), busy, 0);
      check($sformatf("v%0d diff", i), diff, vecs[i].diff);
      check($sformatf("v%0d borrow", i), borrow_out, vecs[i].bo);
      @(posedge clk); #1;
      check($sformatf("v%0d done pulse width", i), done, 0);
      check($sformatf("v%0d held diff", i), diff, vecs[i].diff);
    end

    // Start during SHIFT must be ignored.
    start8(8'h10, 8'h01);
    repeat (2) begin @(posedge clk); #1; end
    a = 8'hFF; b = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done8(3, cyc, bcnt);
    check("ignore latency", cyc, 8);
    check("ignore diff", diff, 8'h0F);
    check("ignore borrow", borrow_out, 0);
    repeat (2) begin @(posedge clk); #1; end
    check("ignore back to idle", {busy, done}, 0);

    // Back-to-back: start held in the DONE cycle.
    start8(8'h5A, 8'h23);
    wait_done8(0, cyc, bcnt);
    check("b2b first latency", cyc, 8);
    check("b2b first diff", diff, 8'h37);
    a = 8'h03; b = 8'h05; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b busy after reaccept", busy, 1);
    check("b2b diff held during shift", diff, 8'h37);
    wait_done8(1, cyc, bcnt);
    check("b2b spacing", cyc, 9);
    check("b2b second diff", diff, 8'hFE);
    check("b2b second borrow", borrow_out, 1);
    @(posedge clk); #1;

    // Reset mid-operation aborts with no done pulse.
    start8(8'h5A, 8'h23);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset diff", diff, 0);
    check("midreset borrow", borrow_out, 0);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("midreset no done/busy", seen, 0);
    start8(8'h00, 8'h01);
    wait_done8(0, cyc, bcnt);
    check("post-reset latency", cyc, 8);
    check("post-reset diff", diff, 8'hFF);
    check("post-reset borrow", borrow_out, 1);
    @(posedge clk); #1;

    // WIDTH=1 instance: done one edge after the accepting edge.
    foreach (vecs1[i]) begin
      a1 = vecs1[i].a; b1 = vecs1[i].b; start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      check($sformatf("w1 v%0d busy", i), busy1, 1);
      @(posedge clk); #1;
      check($sformatf("w1 v%0d done", i), done1, 1);
      check($sformatf("w1 v%0d diff", i), diff1, vecs1[i].diff);
      check($sformatf("w1 v%0d borrow", i), borrow1, vecs1[i].bo);
      @(posedge clk); #1;
      check($sformatf("w1 v%0d idle", i), {busy1, done1}, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
